// File: rtl/fifo_chk_pkg.sv
// Shared types for the hardware FIFO checker: checker states and the
// per-sample mismatch code layout.
package fifo_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } chk_state_e;

  localparam int ERR_DATA      = 0;
  localparam int ERR_WR_ACK    = 1;
  localparam int ERR_OVERFLOW  = 2;
  localparam int ERR_UNDERFLOW = 3;
  localparam int ERR_FULL      = 4;
  localparam int ERR_EMPTY     = 5;
  localparam int ERR_AFULL     = 6;
  localparam int ERR_AEMPTY    = 7;

  typedef logic [7:0] err_code_t;

endpackage

// File: rtl/fifo_scoreboard_hw_if.sv
// Tap on the observed FIFO's ports. The FIFO side drives (master); the
// checker only listens (slave).
interface fifo_scoreboard_hw_if #(
  parameter int FIFO_WIDTH = 16
);
  logic                  mon_rst_n;
  logic                  mon_wr_en;
  logic                  mon_rd_en;
  logic [FIFO_WIDTH-1:0] mon_data_in;
  logic [FIFO_WIDTH-1:0] mon_data_out;
  logic                  mon_wr_ack;
  logic                  mon_overflow;
  logic                  mon_underflow;
  logic                  mon_full;
  logic                  mon_empty;
  logic                  mon_almostfull;
  logic                  mon_almostempty;

  modport master (
    output mon_rst_n, mon_wr_en, mon_rd_en, mon_data_in, mon_data_out,
    output mon_wr_ack, mon_overflow, mon_underflow,
    output mon_full, mon_empty, mon_almostfull, mon_almostempty
  );

  modport slave (
    input mon_rst_n, mon_wr_en, mon_rd_en, mon_data_in, mon_data_out,
    input mon_wr_ack, mon_overflow, mon_underflow,
    input mon_full, mon_empty, mon_almostfull, mon_almostempty
  );
endinterface

// File: rtl/fifo_chk_model.sv
// Shadow FIFO: storage, modulo-DEPTH pointers, occupancy and accept logic.
// Reads return the stored head; a same-edge write never bypasses into it.
module fifo_chk_model #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = $clog2(FIFO_DEPTH + 1),
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [FIFO_WIDTH-1:0] i_data,
  output logic [CW-1:0]         o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_afull,
  output logic                  o_aempty,
  output logic                  o_wr_acc,
  output logic                  o_rd_acc,
  output logic [FIFO_WIDTH-1:0] o_head
);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CW-1:0]         r_count;
  logic [PTR_W-1:0]      w_wptr_nxt;
  logic [PTR_W-1:0]      w_rptr_nxt;

  assign o_count  = r_count;
  assign o_full   = (r_count == CW'(FIFO_DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_afull  = (r_count == CW'(FIFO_DEPTH - 1));
  assign o_aempty = (r_count == CW'(1));
  assign o_wr_acc = i_wr_en && !o_full;
  assign o_rd_acc = i_rd_en && !o_empty;
  assign o_head   = r_mem[r_rptr];

  // Depth need not be a power of two, so wrap explicitly.
  assign w_wptr_nxt = (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt = (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;

  always_ff @(posedge clk) begin
    if (!i_rst && !i_clr && o_wr_acc) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (o_wr_acc) r_wptr <= w_wptr_nxt;
      if (o_rd_acc) r_rptr <= w_rptr_nxt;
      unique case ({o_wr_acc, o_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_scoreboard_hw.sv
// Passive synthesizable FIFO checker: shadow model, per-edge comparison of
// every observed FIFO output, saturating pass/error counters.
//
//   state | meaning
//   IDLE  | checking disabled, shadow model held clear
//   WARM  | first enabled sample: model tracks, only flags compared
//   CHECK | full comparison, counters active
//   HALT  | stopped after a mismatch (STOP_ON_ERR=1), outputs frozen
module fifo_scoreboard_hw
  import fifo_chk_pkg::*;
#(
  parameter int FIFO_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               chk_en,
  fifo_scoreboard_hw_if.slave                mon,
  output logic                               err_flag,
  output err_code_t                          err_code,
  output logic                               err_sticky,
  output logic [CNT_W-1:0]                   err_count,
  output logic [CNT_W-1:0]                   pass_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    model_count,
  output chk_state_e                         state
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  chk_state_e            r_state, w_state_nxt;
  logic                  w_model_clr, w_cmp_flags, w_cmp_regs, w_count_en;
  logic [CW-1:0]         w_count;
  logic                  w_full, w_empty, w_afull, w_aempty;
  logic                  w_wr_acc, w_rd_acc;
  logic [FIFO_WIDTH-1:0] w_head;
  logic                  r_exp_ack, r_exp_ovf, r_exp_unf, r_exp_rd_vld;
  logic [FIFO_WIDTH-1:0] r_exp_data;
  err_code_t             w_err_raw, w_err_code;
  logic                  r_err_flag, r_err_sticky;
  err_code_t             r_err_code;
  logic [CNT_W-1:0]      r_err_count, r_pass_count;

  fifo_chk_model #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_model (
    .clk      (clk),
    .i_rst    (rst),
    .i_clr    (w_model_clr),
    .i_wr_en  (mon.mon_wr_en),
    .i_rd_en  (mon.mon_rd_en),
    .i_data   (mon.mon_data_in),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_afull  (w_afull),
    .o_aempty (w_aempty),
    .o_wr_acc (w_wr_acc),
    .o_rd_acc (w_rd_acc),
    .o_head   (w_head)
  );

  // While the observed FIFO is in reset its flags must read as an empty FIFO
  // and its registered outputs as zero, whatever was pending.
  always_comb begin
    w_err_raw                = '0;
    w_err_raw[ERR_DATA]      = mon.mon_rst_n && r_exp_rd_vld && (mon.mon_data_out != r_exp_data);
    w_err_raw[ERR_WR_ACK]    = mon.mon_wr_ack    != (mon.mon_rst_n && r_exp_ack);
    w_err_raw[ERR_OVERFLOW]  = mon.mon_overflow  != (mon.mon_rst_n && r_exp_ovf);
    w_err_raw[ERR_UNDERFLOW] = mon.mon_underflow != (mon.mon_rst_n && r_exp_unf);
    w_err_raw[ERR_FULL]      = mon.mon_full        != (mon.mon_rst_n && w_full);
    w_err_raw[ERR_EMPTY]     = mon.mon_empty       != (!mon.mon_rst_n || w_empty);
    w_err_raw[ERR_AFULL]     = mon.mon_almostfull  != (mon.mon_rst_n && w_afull);
    w_err_raw[ERR_AEMPTY]    = mon.mon_almostempty != (mon.mon_rst_n && w_aempty);
  end

  assign w_err_code = w_err_raw & {{4{w_cmp_flags}}, {4{w_cmp_regs}}};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_model_clr = 1'b0;
    w_cmp_flags = 1'b0;
    w_cmp_regs  = 1'b0;
    w_count_en  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_model_clr = 1'b1;
        w_state_nxt = WARM;
      end
      WARM: begin
        w_cmp_flags = 1'b1;
        w_state_nxt = CHECK;
      end
      CHECK: begin
        w_cmp_flags = 1'b1;
        w_cmp_regs  = 1'b1;
        w_count_en  = 1'b1;
        if ((STOP_ON_ERR != 0) && (w_err_raw != '0)) w_state_nxt = HALT;
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = IDLE;
    endcase
    if (!chk_en) begin
      w_state_nxt = IDLE;
      w_model_clr = 1'b1;
      w_cmp_flags = 1'b0;
      w_cmp_regs  = 1'b0;
      w_count_en  = 1'b0;
    end
    if (!mon.mon_rst_n) w_model_clr = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || w_model_clr) begin
      r_exp_ack    <= 1'b0;
      r_exp_ovf    <= 1'b0;
      r_exp_unf    <= 1'b0;
      r_exp_rd_vld <= 1'b0;
      r_exp_data   <= '0;
    end else begin
      r_exp_ack    <= w_wr_acc;
      r_exp_ovf    <= mon.mon_wr_en && w_full;
      r_exp_unf    <= mon.mon_rd_en && w_empty;
      r_exp_rd_vld <= w_rd_acc;
      if (w_rd_acc) r_exp_data <= w_head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_flag   <= 1'b0;
      r_err_code   <= '0;
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
      r_pass_count <= '0;
    end else if (!chk_en) begin
      r_err_flag   <= 1'b0;
      r_err_code   <= '0;
      r_err_sticky <= 1'b0;
    end else if (r_state == HALT) begin
      r_err_flag <= 1'b0;
    end else begin
      r_err_flag <= |w_err_code;
      r_err_code <= w_err_code;
      if (|w_err_code) r_err_sticky <= 1'b1;
      if (w_count_en) begin
        if (|w_err_code) begin
          if (r_err_count != {CNT_W{1'b1}}) r_err_count <= r_err_count + 1'b1;
        end else begin
          if (r_pass_count != {CNT_W{1'b1}}) r_pass_count <= r_pass_count + 1'b1;
        end
      end
    end
  end

  assign err_flag    = r_err_flag;
  assign err_code    = r_err_code;
  assign err_sticky  = r_err_sticky;
  assign err_count   = r_err_count;
  assign pass_count  = r_pass_count;
  assign model_count = w_count;
  assign state       = r_state;

endmodule

// File: tb/tb_fifo_scoreboard_hw.sv
// Directed bench: two behavioural FIFOs (depth 8, and depth 5 with stop-on-error)
// each observed by a checker instance; expected read data comes from queues.
module tb_fifo_scoreboard_hw;
  import fifo_chk_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic chk_en_a, chk_en_b;
  logic inj_full0_a, inj_data_b;
  int   checks = 0;
  int   errors = 0;

  fifo_scoreboard_hw_if #(.FIFO_WIDTH(W)) if_a ();
  fifo_scoreboard_hw_if #(.FIFO_WIDTH(W)) if_b ();

  logic       errf_a, errs_a, errf_b, errs_b;
  err_code_t  errc_a, errc_b;
  logic [15:0] errcnt_a, passcnt_a, errcnt_b, passcnt_b;
  logic [3:0] mcnt_a;
  logic [2:0] mcnt_b;
  chk_state_e st_a, st_b;

  fifo_scoreboard_hw #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .CNT_W(16), .STOP_ON_ERR(0)) u_dut_a (
    .clk(clk), .rst(rst), .chk_en(chk_en_a), .mon(if_a.slave),
    .err_flag(errf_a), .err_code(errc_a), .err_sticky(errs_a),
    .err_count(errcnt_a), .pass_count(passcnt_a), .model_count(mcnt_a), .state(st_a));

  fifo_scoreboard_hw #(.FIFO_WIDTH(W), .FIFO_DEPTH(5), .CNT_W(16), .STOP_ON_ERR(1)) u_dut_b (
    .clk(clk), .rst(rst), .chk_en(chk_en_b), .mon(if_b.slave),
    .err_flag(errf_b), .err_code(errc_b), .err_sticky(errs_b),
    .err_count(errcnt_b), .pass_count(passcnt_b), .model_count(mcnt_b), .state(st_b));

  // Observed FIFO A: depth 8, full flag can be forced low.
  logic [W-1:0] mem_a [8];
  logic [2:0]   wp_a, rp_a;
  logic [3:0]   cnt_a;
  wire wa_a = if_a.mon_wr_en && (cnt_a != 4'd8);
  wire ra_a = if_a.mon_rd_en && (cnt_a != 4'd0);
  assign if_a.mon_full        = (cnt_a == 4'd8) && !inj_full0_a;
  assign if_a.mon_empty       = (cnt_a == 4'd0);
  assign if_a.mon_almostfull  = (cnt_a == 4'd7);
  assign if_a.mon_almostempty = (cnt_a == 4'd1);
  always @(posedge clk or negedge if_a.mon_rst_n) begin
    if (!if_a.mon_rst_n) begin
      wp_a <= '0; rp_a <= '0; cnt_a <= '0;
      if_a.mon_wr_ack <= 1'b0; if_a.mon_overflow <= 1'b0;
      if_a.mon_underflow <= 1'b0; if_a.mon_data_out <= '0;
    end else begin
      if (wa_a) begin mem_a[wp_a] <= if_a.mon_data_in; wp_a <= wp_a + 3'd1; end
      if (ra_a) begin if_a.mon_data_out <= mem_a[rp_a]; rp_a <= rp_a + 3'd1; end
      cnt_a <= cnt_a + 4'(wa_a) - 4'(ra_a);
      if_a.mon_wr_ack    <= wa_a;
      if_a.mon_overflow  <= if_a.mon_wr_en && (cnt_a == 4'd8);
      if_a.mon_underflow <= if_a.mon_rd_en && (cnt_a == 4'd0);
    end
  end

  // Observed FIFO B: depth 5, read data can be corrupted to 0x00AA.
  logic [W-1:0] mem_b [5];
  logic [2:0]   wp_b, rp_b, cnt_b;
  wire wa_b = if_b.mon_wr_en && (cnt_b != 3'd5);
  wire rb_b = if_b.mon_rd_en && (cnt_b != 3'd0);
  assign if_b.mon_full        = (cnt_b == 3'd5);
  assign if_b.mon_empty       = (cnt_b == 3'd0);
  assign if_b.mon_almostfull  = (cnt_b == 3'd4);
  assign if_b.mon_almostempty = (cnt_b == 3'd1);
  always @(posedge clk or negedge if_b.mon_rst_n) begin
    if (!if_b.mon_rst_n) begin
      wp_b <= '0; rp_b <= '0; cnt_b <= '0;
      if_b.mon_wr_ack <= 1'b0; if_b.mon_overflow <= 1'b0;
      if_b.mon_underflow <= 1'b0; if_b.mon_data_out <= '0;
    end else begin
      if (wa_b) begin
        mem_b[wp_b] <= if_b.mon_data_in;
        wp_b <= (wp_b == 3'd4) ? 3'd0 : wp_b + 3'd1;
      end
      if (rb_b) begin
        if_b.mon_data_out <= inj_data_b ? 16'h00AA : mem_b[rp_b];
        rp_b <= (rp_b == 3'd4) ? 3'd0 : rp_b + 3'd1;
      end
      cnt_b <= cnt_b + 3'(wa_b) - 3'(rb_b);
      if_b.mon_wr_ack    <= wa_b;
      if_b.mon_overflow  <= if_b.mon_wr_en && (cnt_b == 3'd5);
      if_b.mon_underflow <= if_b.mon_rd_en && (cnt_b == 3'd0);
    end
  end

  logic [W-1:0] sb_a [$];
  logic [W-1:0] sb_b [$];
  int exp_cnt_a = 0;
  int exp_cnt_b = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One FIFO cycle on side b=0 (A) or b=1 (B); expected acceptance comes from
  // the bench's own occupancy, read data from the scoreboard queue.
  task automatic op(input bit b, input logic wr, input logic rd, input logic [W-1:0] d);
    int          depth;
    int          cnt;
    logic        wacc, racc;
    logic [W-1:0] e;
    depth = b ? 5 : 8;
    cnt   = b ? exp_cnt_b : exp_cnt_a;
    wacc  = wr && (cnt != depth);
    racc  = rd && (cnt != 0);
    e     = '0;
    if (b) begin
      if_b.mon_wr_en = wr; if_b.mon_rd_en = rd; if_b.mon_data_in = d;
      if (racc) e = sb_b.pop_front();
      if (wacc) sb_b.push_back(d);
    end else begin
      if_a.mon_wr_en = wr; if_a.mon_rd_en = rd; if_a.mon_data_in = d;
      if (racc) e = sb_a.pop_front();
      if (wacc) sb_a.push_back(d);
    end
    step();
    cnt = cnt + int'(wacc) - int'(racc);
    if (b) begin
      if_b.mon_wr_en = 1'b0; if_b.mon_rd_en = 1'b0;
      exp_cnt_b = cnt;
      if (racc) chk("b_data_out", 32'(if_b.mon_data_out), 32'(e));
      chk("b_model_count", 32'(mcnt_b), 32'(cnt));
      chk("b_err_flag", 32'(errf_b), 32'd0);
    end else begin
      if_a.mon_wr_en = 1'b0; if_a.mon_rd_en = 1'b0;
      exp_cnt_a = cnt;
      if (racc) chk("a_data_out", 32'(if_a.mon_data_out), 32'(e));
      chk("a_model_count", 32'(mcnt_a), 32'(cnt));
      chk("a_err_flag", 32'(errf_a), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; chk_en_a = 1'b0; chk_en_b = 1'b0;
    inj_full0_a = 1'b0; inj_data_b = 1'b0;
    if_a.mon_rst_n = 1'b0; if_a.mon_wr_en = 1'b0; if_a.mon_rd_en = 1'b0; if_a.mon_data_in = '0;
    if_b.mon_rst_n = 1'b0; if_b.mon_wr_en = 1'b0; if_b.mon_rd_en = 1'b0; if_b.mon_data_in = '0;
    repeat (3) step();
    chk("rst_state_a", 32'(st_a), 32'(IDLE));
    chk("rst_state_b", 32'(st_b), 32'(IDLE));
    chk("rst_err_flag", 32'(errf_a), 32'd0);
    chk("rst_err_code", 32'(errc_a), 32'd0);
    chk("rst_err_sticky", 32'(errs_a), 32'd0);
    chk("rst_err_count", 32'(errcnt_a), 32'd0);
    chk("rst_pass_count", 32'(passcnt_a), 32'd0);
    chk("rst_model_count", 32'(mcnt_a), 32'd0);
    rst = 1'b0; if_a.mon_rst_n = 1'b1; if_b.mon_rst_n = 1'b1;
    step();

    // Depth 8: fill then drain in order
    chk_en_a = 1'b1;
    step();
    chk("a_warm", 32'(st_a), 32'(WARM));
    step();
    chk("a_check", 32'(st_a), 32'(CHECK));
    chk("a_warm_not_counted", 32'(passcnt_a), 32'd0);
    for (int i = 1; i <= 8; i++) op(1'b0, 1'b1, 1'b0, 16'(i));
    for (int i = 0; i < 8; i++) op(1'b0, 1'b0, 1'b1, '0);
    op(1'b0, 1'b0, 1'b0, '0);
    chk("a_pass_17", 32'(passcnt_a), 32'd17);
    chk("a_err_0", 32'(errcnt_a), 32'd0);

    // Nine writes: ninth is an overflow and is not acknowledged
    for (int i = 0; i < 9; i++) op(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i));
    chk("a_ovf_seen", 32'(if_a.mon_overflow), 32'd1);
    chk("a_ack_low", 32'(if_a.mon_wr_ack), 32'd0);
    op(1'b0, 1'b0, 1'b0, '0);
    chk("a_ovf_no_err", 32'(errcnt_a), 32'd0);
    chk("a_pass_27", 32'(passcnt_a), 32'd27);

    // Full stuck low while the FIFO is full
    inj_full0_a = 1'b1;
    step();
    inj_full0_a = 1'b0;
    chk("a_full_err_flag", 32'(errf_a), 32'd1);
    chk("a_full_err_code", 32'(errc_a), 32'h10);
    chk("a_full_err_count", 32'(errcnt_a), 32'd1);
    chk("a_full_sticky", 32'(errs_a), 32'd1);
    step();
    chk("a_flag_pulse", 32'(errf_a), 32'd0);
    chk("a_sticky_held", 32'(errs_a), 32'd1);
    chk("a_no_halt", 32'(st_a), 32'(CHECK));
    chk("a_pass_28", 32'(passcnt_a), 32'd28);

    // Drain, then one read from empty (underflow expected, not an error)
    for (int i = 0; i < 8; i++) op(1'b0, 1'b0, 1'b1, '0);
    op(1'b0, 1'b0, 1'b1, '0);
    chk("a_unf_seen", 32'(if_a.mon_underflow), 32'd1);
    op(1'b0, 1'b0, 1'b0, '0);
    chk("a_pass_38", 32'(passcnt_a), 32'd38);
    chk("a_err_still_1", 32'(errcnt_a), 32'd1);

    // Observed-FIFO reset at count 3 with a read still pending compare
    for (int i = 0; i < 4; i++) op(1'b0, 1'b1, 1'b0, 16'h0A00 + 16'(i));
    op(1'b0, 1'b0, 1'b1, '0);
    if_a.mon_rst_n = 1'b0;
    step();
    chk("a_mrst_count", 32'(mcnt_a), 32'd0);
    chk("a_mrst_flag", 32'(errf_a), 32'd0);
    chk("a_mrst_code", 32'(errc_a), 32'd0);
    if_a.mon_rst_n = 1'b1;
    sb_a.delete();
    exp_cnt_a = 0;
    step();
    chk("a_post_mrst_flag", 32'(errf_a), 32'd0);
    op(1'b0, 1'b1, 1'b0, 16'hBEEF);
    op(1'b0, 1'b0, 1'b1, '0);
    op(1'b0, 1'b0, 1'b0, '0);
    chk("a_post_mrst_err", 32'(errcnt_a), 32'd1);

    // Depth 5: hold count 4 through 12 simultaneous read+write cycles
    chk_en_b = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++) op(1'b1, 1'b1, 1'b0, 16'h0200 + 16'(i));
    for (int i = 0; i < 12; i++) op(1'b1, 1'b1, 1'b1, 16'h0300 + 16'(i));
    chk("b_err_0", 32'(errcnt_b), 32'd0);
    chk("b_pass_16", 32'(passcnt_b), 32'd16);
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 1'b1, '0);
    op(1'b1, 1'b1, 1'b0, 16'h0055);

    // Corrupted read data with stop-on-error
    inj_data_b = 1'b1;
    if_b.mon_rd_en = 1'b1;
    void'(sb_b.pop_front());
    exp_cnt_b = 0;
    step();
    if_b.mon_rd_en = 1'b0;
    inj_data_b = 1'b0;
    chk("b_pass_22", 32'(passcnt_b), 32'd22);
    step();
    chk("b_data_err_code", 32'(errc_b), 32'h01);
    chk("b_data_err_flag", 32'(errf_b), 32'd1);
    chk("b_data_err_count", 32'(errcnt_b), 32'd1);
    chk("b_halt", 32'(st_b), 32'(HALT));
    repeat (3) step();
    chk("b_halt_pass_frozen", 32'(passcnt_b), 32'd22);
    chk("b_halt_err_frozen", 32'(errcnt_b), 32'd1);
    chk("b_halt_code_frozen", 32'(errc_b), 32'h01);
    chk("b_halt_state", 32'(st_b), 32'(HALT));
    chk("b_halt_sticky", 32'(errs_b), 32'd1);
    chk_en_b = 1'b0;
    step();
    chk("b_idle", 32'(st_b), 32'(IDLE));
    chk("b_sticky_clr", 32'(errs_b), 32'd0);
    chk("b_code_clr", 32'(errc_b), 32'd0);
    chk("b_model_clr", 32'(mcnt_b), 32'd0);
    chk_en_b = 1'b1;
    step();
    step();
    chk("b_recheck", 32'(st_b), 32'(CHECK));
    step();
    chk("b_pass_resumed", 32'(passcnt_b), 32'd23);
    chk("b_err_kept", 32'(errcnt_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_scoreboard_hw.md
# fifo_scoreboard_hw

Synthesisable, parametrised FIFO checker that passively samples a synchronous FIFO's port signals each rising clock edge. It runs a cycle-accurate shadow model (storage, pointers, occupancy) and compares every DUT output against it. It keeps saturating pass/error counters and a per-cycle error code. It sits beside the FIFO in emulation/FPGA builds, where the simulation-only monitor and scoreboard cannot run, and generalises them to any width/depth with an optional stop-on-error mode.

## Interface
Parameters:
- FIFO_WIDTH, 16, data width of the observed FIFO
- FIFO_DEPTH, 8, depth of the observed FIFO (≥2, any integer, not only powers of two)
- CNT_W, 16, width of the pass/error counters
- STOP_ON_ERR, 0, 1 = freeze checking after first mismatch

Ports:
- clk  in  1  single clock, shared with the observed FIFO
- rst  in  1  synchronous, active-high reset (checker only)
- chk_en  in  1  checking enable
- mon_rst_n  in  1  observed FIFO's active-low reset
- mon_wr_en, mon_rd_en  in  1  observed FIFO requests
- mon_data_in  in  FIFO_WIDTH  observed write data
- mon_data_out  in  FIFO_WIDTH  observed read data
- mon_wr_ack, mon_overflow, mon_underflow  in  1  observed registered status
- mon_full, mon_empty, mon_almostfull, mon_almostempty  in  1  observed combinational flags
- err_flag  out  1  one-cycle pulse per mismatching sample
- err_code  out  8  mismatch bits of that sample
- err_sticky  out  1  set on any mismatch, cleared only by rst or chk_en low
- err_count, pass_count  out  CNT_W  saturating counters
- model_count  out  $clog2(FIFO_DEPTH+1)  shadow occupancy
- state  out  2  checker state (package enum)

## Operation
- Golden semantics: write accepted iff wr_en && !full; read accepted iff rd_en && !empty; both accepted on the same cycle when neither is full nor empty. Occupancy moves only on accepted operations. When full with both requested, only the read is accepted. When empty with both requested, only the write is accepted.
- Registered expectations, computed at edge N and compared at edge N+1:
  - wr_ack = write accepted
  - overflow = wr_en && full
  - underflow = rd_en && empty
  - data_out = head word, only when a read was accepted
- Combinational flag expectations, from model occupancy at the sampling edge:
  - full: count==DEPTH
  - empty: count==0
  - almostfull: count==DEPTH-1
  - almostempty: count==1
- err_code bits: 0 data_out, 1 wr_ack, 2 overflow, 3 underflow, 4 full, 5 empty, 6 almostfull, 7 almostempty.
- Each CHECK sample increments exactly one counter: err_count if err_code≠0, else pass_count. Counters saturate at all-ones.
- State machine:
  - IDLE: chk_en=0; model cleared; no counting.
  - WARM: first enabled cycle. Model tracks, flags compared, registered outputs not compared. → CHECK.
  - CHECK: full comparison.
  - HALT: entered from CHECK on mismatch when STOP_ON_ERR=1. Counters and err outputs frozen.
  - chk_en low from any state → IDLE.
- mon_rst_n low: model occupancy/pointers cleared and all registered expectations forced 0. The sample is still compared, so DUT flags must then read empty=1, full=0.
- Pointers wrap at FIFO_DEPTH-1 → 0 (modulo DEPTH, not power-of-two).

## Timing
- rst: every output 0; state=IDLE. err_count and pass_count reset to 0.
- Mismatch sampled at edge N: err_flag/err_code/err_count/err_sticky are valid after edge N and err_flag lasts one cycle.
- Shadow write and read of the same word on the same edge: the read returns the pre-write head, because a write never bypasses into a read.
- mon_rst_n asserted mid-burst: expectations from the prior cycle are discarded. No data compare occurs on the following edge.

## Structure
- Package fifo_chk_pkg holds:
  - chk_state_e enum (IDLE, WARM, CHECK, HALT)
  - ERR_* bit-index constants
  - err_code_t typedef
- Sub-module fifo_chk_model: shadow memory, modulo pointers, occupancy, accept logic. The top level holds the FSM, comparators and counters.

## Test plan
- DEPTH=8: eight writes 0x0001..0x0008 then eight reads. Expected: pass_count=17 after WARM, err_count=0, data out in order.
- Write 9 words into a DEPTH=8 FIFO. Expected: the 9th write has expected overflow=1 and wr_ack=0, model_count stays 8, no error.
- DUT with full stuck at 0. Expected: err_code=0x10 on the first full sample, err_flag pulses, err_count=1.
- STOP_ON_ERR=1 with a corrupted data_out (0x00AA vs 0x0055). Expected: err_code=0x01, state=HALT, counters frozen until chk_en toggles.
- DEPTH=5: 12 interleaved simultaneous read+write cycles at count 4. Expected: pointer wrap, count stays 4, zero errors.
- mon_rst_n pulsed with count=3. Expected: model_count=0 and no spurious data error next edge.
